// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encoding, BCD sizing and the double-dabble digit correction
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 16;

    typedef logic [3:0] bcd_digit_t;

    // A digit is at most 9 before correction, so +3 never overflows 4 bits.
    function automatic bcd_digit_t dabble_adj(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_convert_scheduler_if.sv
// rtl/bcd_convert_scheduler_if.sv - requester bus; bcd_hold exists only with BCD_SCHED_HOLD_EN
interface bcd_convert_scheduler_if #(
    parameter int NUM_REQ   = 4,
    parameter int BIN_WIDTH = 13,
    parameter int ID_W      = 2
);
    import bcd_pkg::*;

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*BIN_WIDTH-1:0] bin_in;
    logic [NUM_REQ-1:0]           grant;
    logic                         busy;
    logic                         done;
    logic [ID_W-1:0]              done_id;
    logic [BCD_W-1:0]             bcd_out;
`ifdef BCD_SCHED_HOLD_EN
    logic [NUM_REQ*BCD_W-1:0]     bcd_hold;

    modport master (output req, bin_in, input grant, busy, done, done_id, bcd_out, bcd_hold);
    modport slave  (input req, bin_in, output grant, busy, done, done_id, bcd_out, bcd_hold);
`else
    modport master (output req, bin_in, input grant, busy, done, done_id, bcd_out);
    modport slave  (input req, bin_in, output grant, busy, done, done_id, bcd_out);
`endif

endinterface

// File: rtl/bcd_shift_engine.sv
// rtl/bcd_shift_engine.sv - one-bit-per-cycle double-dabble engine; runs while its counter is nonzero
module bcd_shift_engine
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 13
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic [BIN_WIDTH-1:0] i_operand,
    output logic                 o_last_iter,
    output logic [BCD_W-1:0]     o_digits
);
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    logic [BIN_WIDTH-1:0]       r_bin;
    logic [BCD_W-1:0]           r_digits;
    logic [CNT_W-1:0]           r_cnt;
    logic [BCD_W-1:0]           w_adj;
    logic [BCD_W+BIN_WIDTH-1:0] w_next;

    always_comb begin
        w_adj = r_digits;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            w_adj[d*4 +: 4] = dabble_adj(r_digits[d*4 +: 4]);
        end
        w_next = {w_adj, r_bin} << 1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bin    <= '0;
            r_digits <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_bin    <= i_operand;
            r_digits <= '0;
            r_cnt    <= CNT_W'(BIN_WIDTH);
        end else if (r_cnt != '0) begin
            r_digits <= w_next[BCD_W+BIN_WIDTH-1:BIN_WIDTH];
            r_bin    <= w_next[BIN_WIDTH-1:0];
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    assign o_last_iter = (r_cnt == CNT_W'(1));
    assign o_digits    = r_digits;

endmodule

// File: rtl/bcd_convert_scheduler.sv
// rtl/bcd_convert_scheduler.sv - round-robin arbiter and FSM sharing one BCD engine
// Optional per-requester result hold registers under BCD_SCHED_HOLD_EN.
module bcd_convert_scheduler
    import bcd_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BIN_WIDTH = 13,
    parameter int ID_W      = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    bcd_convert_scheduler_if.slave  bus
);
    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_busy;
    logic                 r_done;
    logic [ID_W-1:0]      r_done_id;
    logic [BCD_W-1:0]     r_bcd_out;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_tag;

    logic [BIN_WIDTH-1:0] w_ops [NUM_REQ];
    logic [NUM_REQ-1:0]   w_onehot;
    logic                 w_found;
    logic [ID_W-1:0]      w_sel;
    logic [ID_W-1:0]      w_idx;
    logic [ID_W-1:0]      w_ptr_next;
    logic                 w_load;
    logic                 w_last_iter;
    logic [BCD_W-1:0]     w_digits;

    // First set request at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_onehot = '0;
        w_found  = 1'b0;
        w_sel    = '0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ops[i] = bus.bin_in[i*BIN_WIDTH +: BIN_WIDTH];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = ID_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found         = 1'b1;
                w_sel           = w_idx;
                w_onehot[w_idx] = 1'b1;
            end
        end
        w_ptr_next = (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
    end

    assign w_load = (r_state == IDLE) && w_found;

    bcd_shift_engine #(.BIN_WIDTH(BIN_WIDTH)) u_engine (
        .clock       (clock),
        .reset       (reset),
        .i_load      (w_load),
        .i_operand   (w_ops[w_sel]),
        .o_last_iter (w_last_iter),
        .o_digits    (w_digits)
    );

`ifdef BCD_SCHED_HOLD_EN
    logic [BCD_W-1:0] r_hold [NUM_REQ];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) r_hold[i] <= '0;
        end else if (r_state == DONE) begin
            r_hold[r_tag] <= w_digits;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
        assign bus.bcd_hold[g*BCD_W +: BCD_W] = r_hold[g];
    end
`endif

    // busy follows the state by one cycle so it stays high through the done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_bcd_out <= '0;
            r_ptr     <= '0;
            r_tag     <= '0;
        end else begin
            r_grant <= '0;
            r_done  <= 1'b0;
            r_busy  <= (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_onehot;
                        r_tag   <= w_sel;
                        r_ptr   <= w_ptr_next;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_last_iter) r_state <= DONE;
                end
                DONE: begin
                    r_done    <= 1'b1;
                    r_bcd_out <= w_digits;
                    r_done_id <= r_tag;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant   = r_grant;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.bcd_out = r_bcd_out;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb/tb_bcd_convert_scheduler.sv - directed table-driven bench for bcd_convert_scheduler
module tb_bcd_convert_scheduler;
    localparam int NUM_REQ   = 4;
    localparam int BIN_WIDTH = 13;
    localparam int ID_W      = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    bcd_convert_scheduler_if #(.NUM_REQ(NUM_REQ), .BIN_WIDTH(BIN_WIDTH), .ID_W(ID_W)) bus_if ();

    bcd_convert_scheduler #(.NUM_REQ(NUM_REQ), .BIN_WIDTH(BIN_WIDTH), .ID_W(ID_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          k;
        logic [12:0] val;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input string name, output logic ok, output int t);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bus_if.grant !== '0) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
        if (!ok) check({name, "_grant_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string name, input int t_grant, output logic ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (i == 0) check({name, "_busy"}, 32'(bus_if.busy), 32'd1);
            if (bus_if.done === 1'b1) begin
                ok  = 1'b1;
                lat = cyc - t_grant;
                break;
            end
        end
        if (!ok) check({name, "_done_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic run_one(input int k, input logic [12:0] val, input logic [15:0] exp, input string name);
        logic ok;
        int   t;
        int   lat;
        bus_if.bin_in[k*BIN_WIDTH +: BIN_WIDTH] = val;
        bus_if.req[k] = 1'b1;
        wait_grant(name, ok, t);
        bus_if.req[k] = 1'b0;
        if (ok) begin
            check({name, "_grant"}, 32'(bus_if.grant), 32'(1 << k));
            wait_done(name, t, ok, lat);
            if (ok) begin
                check({name, "_latency"}, 32'(lat), 32'd14);
                check({name, "_bcd"}, 32'(bus_if.bcd_out), 32'(exp));
                check({name, "_id"}, 32'(bus_if.done_id), 32'(k));
                @(negedge clock);
                check({name, "_done_pulse"}, 32'(bus_if.done), 32'd0);
                check({name, "_id_held"}, 32'(bus_if.done_id), 32'(k));
            end
        end
    endtask

    initial begin
        logic ok;
        int   t;
        int   t_prev;
        int   lat;
        int   n_done;
        logic [15:0] exp_c [4];
        logic [15:0] exp_hold [4];

        vecs[0] = '{0, 13'd1234, 16'h1234};
        vecs[1] = '{2, 13'd0,    16'h0000};
        vecs[2] = '{2, 13'd8191, 16'h8191};
        vecs[3] = '{2, 13'd5,    16'h0005};
        vecs[4] = '{2, 13'd999,  16'h0999};
        vecs[5] = '{1, 13'd4095, 16'h4095};
        vecs[6] = '{0, 13'd10,   16'h0010};
        vecs[7] = '{3, 13'd100,  16'h0100};

        bus_if.req    = '0;
        bus_if.bin_in = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_grant",   32'(bus_if.grant),   32'd0);
        check("rst_busy",    32'(bus_if.busy),    32'd0);
        check("rst_done",    32'(bus_if.done),    32'd0);
        check("rst_done_id", 32'(bus_if.done_id), 32'd0);
        check("rst_bcd",     32'(bus_if.bcd_out), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_one(vecs[i].k, vecs[i].val, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Contention: pointer is 0 after the last vector used requester 3.
        exp_c = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        for (int i = 0; i < NUM_REQ; i++) begin
            bus_if.bin_in[i*BIN_WIDTH +: BIN_WIDTH] = 13'(11 * (i + 1));
        end
        bus_if.req = 4'b1111;
        t_prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant($sformatf("rr%0d", g), ok, t);
            if (!ok) break;
            check($sformatf("rr%0d_grant", g), 32'(bus_if.grant), 32'(1 << (g % 4)));
            if (g > 0) check($sformatf("rr%0d_spacing", g), 32'(t - t_prev), 32'd15);
            t_prev = t;
            wait_done($sformatf("rr%0d", g), t, ok, lat);
            if (!ok) break;
            check($sformatf("rr%0d_id", g), 32'(bus_if.done_id), 32'(g % 4));
            check($sformatf("rr%0d_bcd", g), 32'(bus_if.bcd_out), 32'(exp_c[g % 4]));
        end
        bus_if.req = '0;
        repeat (2) @(negedge clock);

        // Pointer is 1; one conversion on requester 2 moves it to 3.
        run_one(2, 13'd3000, 16'h3000, "ptr_set");
        bus_if.bin_in[0*BIN_WIDTH +: BIN_WIDTH] = 13'd77;
        bus_if.bin_in[3*BIN_WIDTH +: BIN_WIDTH] = 13'd88;
        bus_if.req = 4'b1001;
        wait_grant("wrap_a", ok, t);
        bus_if.req[3] = 1'b0;
        if (ok) begin
            check("wrap_a_grant", 32'(bus_if.grant), 32'b1000);
            wait_done("wrap_a", t, ok, lat);
            if (ok) begin
                check("wrap_a_id",  32'(bus_if.done_id), 32'd3);
                check("wrap_a_bcd", 32'(bus_if.bcd_out), 32'h0088);
                wait_grant("wrap_b", ok, t);
                bus_if.req[0] = 1'b0;
                if (ok) begin
                    check("wrap_b_grant", 32'(bus_if.grant), 32'b0001);
                    wait_done("wrap_b", t, ok, lat);
                    if (ok) begin
                        check("wrap_b_id",  32'(bus_if.done_id), 32'd0);
                        check("wrap_b_bcd", 32'(bus_if.bcd_out), 32'h0077);
                    end
                end
            end
        end
        bus_if.req = '0;
        repeat (2) @(negedge clock);

        // Reset in the middle of a conversion.
        bus_if.bin_in[2*BIN_WIDTH +: BIN_WIDTH] = 13'd1000;
        bus_if.req[2] = 1'b1;
        wait_grant("mid_rst", ok, t);
        bus_if.req[2] = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus_if.done === 1'b1) n_done++;
        end
        check("mid_rst_no_done", 32'(n_done),         32'd0);
        check("mid_rst_bcd",     32'(bus_if.bcd_out), 32'd0);
        check("mid_rst_busy",    32'(bus_if.busy),    32'd0);
        check("mid_rst_grant",   32'(bus_if.grant),   32'd0);
        check("mid_rst_id",      32'(bus_if.done_id), 32'd0);
        run_one(1, 13'd2468, 16'h2468, "post_rst");

`ifdef BCD_SCHED_HOLD_EN
        run_one(1, 13'd42, 16'h0042, "hold_a");
        run_one(3, 13'd7,  16'h0007, "hold_b");
        exp_hold = '{16'h0000, 16'h0042, 16'h0000, 16'h0007};
        for (int i = 0; i < NUM_REQ; i++) begin
            check($sformatf("hold_slice%0d", i), 32'(bus_if.bcd_hold[i*16 +: 16]), 32'(exp_hold[i]));
        end
`else
        exp_hold = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        check("hold_absent_idle_busy", 32'(bus_if.busy), 32'(exp_hold[0]));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_convert_scheduler.md
Name: bcd_convert_scheduler

Overview:
- Shares one iterative, one-bit-per-cycle double-dabble BCD engine between NUM_REQ requesters, e.g. the seven-segment display paths of the five-stage pipelined computer (PC, ALU result, I/O ports).
- Round-robin arbiter, req/grant handshake and a tagged one-cycle done pulse.
- Replaces several combinational converters with one small sequential engine.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- BIN_WIDTH, 13: binary operand width. Must be 1..13 so that the maximum value 8191 fits in 4 BCD digits.
- ID_W, 2: width of done_id. Equals clog2(NUM_REQ).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  request level. Bit i is held by requester i until it sees grant[i].
- bin_in  in  NUM_REQ*BIN_WIDTH  flattened operands. Requester i uses bin_in[i*BIN_WIDTH +: BIN_WIDTH].
- grant  out  NUM_REQ  one-hot, one-cycle pulse. The operand is captured in the same cycle.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; the result is valid.
- done_id  out  ID_W  index of the requester that owns the result. Valid with done and held afterwards.
- bcd_out  out  16  result as {thousands, hundreds, tens, ones}, 4 bits each. Held until the next done.

Behaviour:
- Clock and reset: single clock domain, clock. Reset is synchronous and active-high, port reset.
- Reset values: state=IDLE, grant=0, busy=0, done=0, done_id=0, bcd_out=0, round-robin pointer=0, shift counter=0, digit registers=0.
- IDLE:
  - If req!=0, grant the first set bit searching from pointer upward, modulo NUM_REQ.
  - grant[k]=1 for this cycle only.
  - Load the shift register with bin_in slice k and clear the digit registers.
  - Set counter=BIN_WIDTH and pointer=(k+1) mod NUM_REQ, then go to SHIFT.
  - If req==0, stay in IDLE with grant=0.
- SHIFT, one iteration per cycle:
  - Add 3 to each digit that is >=5, 4-bit wrap-free because a digit is at most 9 before correction.
  - Shift {thousands, hundreds, tens, ones, operand} left by 1, so the operand MSB enters ones[0].
  - Decrement counter. When counter reaches 1 this cycle, go to DONE.
- DONE:
  - done=1. bcd_out and done_id are registered from the digit registers and the tag.
  - Next state is IDLE. No grant is issued in DONE.
- Latency and throughput:
  - grant in cycle T, done in cycle T+BIN_WIDTH+1 (T+14 at default).
  - Earliest next grant is T+BIN_WIDTH+2, so sustained throughput is one conversion per 15 cycles.
- Handshake rules:
  - A requester must drop req in the cycle after grant. req still high in a later IDLE cycle is a new request.
  - req and bin_in changes during SHIFT or DONE are ignored because the operand was already captured.
- Boundaries:
  - Operand 0 gives 0x0000. Operand 8191 gives 0x8191.
  - Pointer wraps from NUM_REQ-1 to 0.
  - Simultaneous requests are serviced in pointer order with no starvation. The worst-case wait is NUM_REQ-1 conversions.
- Reset mid-operation: abort immediately to IDLE. No done is issued, bcd_out=0 and the pointer returns to 0.

Optional Feature:
- Macro: BCD_SCHED_HOLD_EN.
- Defined:
  - Adds output bcd_hold of width NUM_REQ*16, holding per-requester last results. Slice i is bcd_hold[i*16 +: 16].
  - Slice done_id is updated in the DONE cycle and is visible the cycle after. The other slices are unchanged.
  - All slices reset to 0.
  - Each display can read its own digits continuously.
- Undefined: port and registers absent; only bcd_out and done_id are available.

Decomposition:
- Shared package bcd_pkg holds:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - BCD_DIGITS=4 and BCD_W=16.
  - Digit typedef bcd_digit_t, 4 bits.
- One sub-module, bcd_shift_engine:
  - Holds the digit and operand registers, counter and per-cycle add-3/shift.
  - Inputs: load, operand. Outputs: last_iter, digits.
- The arbiter and FSM stay in the top level.

Test Plan:
- Single request: req=0001, bin_in[0]=1234 -> grant=0001 at T, busy from T+1, done at T+14 with bcd_out=16'h1234 and done_id=0.
- Extremes on requester 2: operand 0 -> bcd_out=16'h0000; operand 8191 -> 16'h8191; operand 5 -> 16'h0005; operand 999 -> 16'h0999.
- Contention: req=1111 held and re-asserted after each grant, pointer starts at 0 -> grants in order 0,1,2,3,0 with grants 15 cycles apart; each done_id matches the grant order.
- Fairness after wrap: pointer=3, req=1001 -> grant 3 first, then 0.
- Reset in SHIFT: assert reset at T+6 -> no done pulse, state IDLE, bcd_out=0, next req=0010 -> grant 0010 and a correct result 14 cycles later.
- With BCD_SCHED_HOLD_EN: convert 42 for requester 1 and then 7 for requester 3 -> bcd_hold slice 1=16'h0042, slice 3=16'h0007, slices 0 and 2=0.
